rvh_l1d_ld_wb_queue: RTL and testbench



---
 rtl/rvh_l1d_pkg.sv | 21 ++
 rtl/rvh_l1d_wb_fifo.sv | 62 ++++++
 rtl/rvh_l1d_ld_wb_queue.sv | 153 +++++++++++++++
 tb/tb_rvh_l1d_ld_wb_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// rvh_l1d_pkg: shared widths and the load-writeback entry layout for the
// L1D load-writeback path.
package rvh_l1d_pkg;

  localparam int ROB_TAG_WIDTH      = 4;
  localparam int PREG_TAG_WIDTH     = 4;
  localparam int RRV64_LSU_ID_WIDTH = 12;
  localparam int XLEN               = 64;
  localparam int PTW_ID_WIDTH       = 2;
  localparam int PTE_WIDTH          = 12;

  // One buffered load writeback, ordered as it is packed in the queue storage.
  typedef struct packed {
    logic [ROB_TAG_WIDTH-1:0]      rob_tag;
    logic [PREG_TAG_WIDTH-1:0]     prd;
    logic [XLEN-1:0]               data;
    logic                          from_mlfb;
    logic [RRV64_LSU_ID_WIDTH-1:0] lsu_tag;
  } rvh_l1d_ld_wb_entry_t;

endpackage

// File: rtl/rvh_l1d_wb_fifo.sv
// rvh_l1d_wb_fifo: generic DEPTH-entry circular FIFO with an occupancy count.
// A push that finds the FIFO full with no pop in the same cycle is dropped and
// reported on drop_o for one cycle; the caller keeps any sticky status.
module rvh_l1d_wb_fifo #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 drop_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 push_ok;
  logic                 pop_ok;

  // Accept/pop decisions and next pointer/count; a pop frees the slot a full push needs.
  always_comb begin
    pop_ok   = pop_i & (cnt_q != '0);
    push_ok  = push_i & ((cnt_q != FULL_CNT) | pop_ok);
    drop_o   = push_i & ~push_ok;
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_ok);
    cnt_d    = cnt_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
  end

  // Pointer and count registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/rvh_l1d_ld_wb_queue.sv
// rvh_l1d_ld_wb_queue: absorbs the non-stallable bank load-response writeback
// and PTW pulses, drains them under valid/ready and raises an early load stall.
// Optional feature: define RVH_L1D_LD_WB_BYPASS_EN to let a load on an empty
// queue appear on the writeback outputs in the same cycle.
module rvh_l1d_ld_wb_queue #(
  parameter int DEPTH          = 4,
  parameter int STALL_THRESH   = 1,
  parameter int ROB_TAG_WIDTH  = rvh_l1d_pkg::ROB_TAG_WIDTH,
  parameter int PREG_TAG_WIDTH = rvh_l1d_pkg::PREG_TAG_WIDTH,
  parameter int LSU_ID_WIDTH   = rvh_l1d_pkg::RRV64_LSU_ID_WIDTH,
  parameter int XLEN           = rvh_l1d_pkg::XLEN,
  parameter int PTW_ID_WIDTH   = rvh_l1d_pkg::PTW_ID_WIDTH,
  parameter int PTE_WIDTH      = rvh_l1d_pkg::PTE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_wb_vld_i,
  input  logic [ROB_TAG_WIDTH-1:0]       in_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0]      in_prd_i,
  input  logic [XLEN-1:0]                in_data_i,
  input  logic                           in_from_mlfb_i,
  input  logic [LSU_ID_WIDTH-1:0]        in_lsu_tag_i,
  input  logic                           in_ptw_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]        in_ptw_id_i,
  input  logic [PTE_WIDTH-1:0]           in_ptw_pte_i,
  input  logic                           wb_rdy_i,
  output logic                           l1d_rob_wb_vld_o,
  output logic                           l1d_int_prf_wb_vld_o,
  output logic [ROB_TAG_WIDTH-1:0]       l1d_rob_wb_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0]      l1d_int_prf_wb_tag_o,
  output logic [XLEN-1:0]                l1d_int_prf_wb_data_o,
  output logic                           l1d_int_prf_wb_vld_from_mlfb_o,
  output logic [LSU_ID_WIDTH-1:0]        l1d_lsu_lsu_tag_o,
  input  logic                           ptw_walk_rdy_i,
  output logic                           l1d_ptw_walk_vld_o,
  output logic [PTW_ID_WIDTH-1:0]        l1d_ptw_walk_id_o,
  output logic [PTE_WIDTH-1:0]           l1d_ptw_walk_pte_o,
  output logic                           ld_stall_o,
  output logic [$clog2(DEPTH+1)-1:0]     free_cnt_o,
  output logic                           overflow_o
);

  import rvh_l1d_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ROB_TAG_WIDTH + PREG_TAG_WIDTH + XLEN + 1 + LSU_ID_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(STALL_THRESH);

  logic [ENTRY_W-1:0]        in_entry;
  logic [ENTRY_W-1:0]        fifo_data;
  logic [ENTRY_W-1:0]        head_entry;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      fifo_nonempty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      ld_drop;
  logic                      head_vld;
  logic                      head_from_mlfb;

  logic                      ptw_v_q, ptw_v_d;
  logic [PTW_ID_WIDTH-1:0]   ptw_id_q, ptw_id_d;
  logic [PTE_WIDTH-1:0]      ptw_pte_q, ptw_pte_d;
  logic                      ptw_drop;
  logic                      overflow_q, overflow_d;

  assign in_entry      = {in_rob_tag_i, in_prd_i, in_data_i, in_from_mlfb_i, in_lsu_tag_i};
  assign fifo_nonempty = (fifo_cnt != '0);

`ifdef RVH_L1D_LD_WB_BYPASS_EN
  logic bypass_hit;

  // Head selection with bypass: an empty queue shows the incoming load directly,
  // and skips storing it when the writeback port takes it this cycle.
  always_comb begin
    bypass_hit = in_wb_vld_i & ~fifo_nonempty;
    head_vld   = fifo_nonempty | bypass_hit;
    head_entry = bypass_hit ? in_entry : fifo_data;
    fifo_push  = in_wb_vld_i & ~(bypass_hit & wb_rdy_i);
    fifo_pop   = fifo_nonempty & wb_rdy_i;
  end
`else
  // Head selection without bypass: outputs come only from stored entries.
  always_comb begin
    head_vld   = fifo_nonempty;
    head_entry = fifo_data;
    fifo_push  = in_wb_vld_i;
    fifo_pop   = fifo_nonempty & wb_rdy_i;
  end
`endif

  rvh_l1d_wb_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (ENTRY_W),
    .CNT_WIDTH (CNT_W)
  ) u_ld_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .data_i (in_entry),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .cnt_o  (fifo_cnt),
    .drop_o (ld_drop)
  );

  assign {l1d_rob_wb_rob_tag_o, l1d_int_prf_wb_tag_o, l1d_int_prf_wb_data_o,
          head_from_mlfb, l1d_lsu_lsu_tag_o} = head_entry;

  assign l1d_rob_wb_vld_o               = head_vld;
  assign l1d_int_prf_wb_vld_o           = head_vld;
  assign l1d_int_prf_wb_vld_from_mlfb_o = head_vld & head_from_mlfb;

  assign free_cnt_o = DEPTH_CNT - fifo_cnt;
  assign ld_stall_o = (free_cnt_o <= THRESH_CNT);

  // PTW holding register: reload when empty or draining, drop when held and blocked.
  always_comb begin
    ptw_v_d   = ptw_v_q;
    ptw_id_d  = ptw_id_q;
    ptw_pte_d = ptw_pte_q;
    ptw_drop  = in_ptw_vld_i & ptw_v_q & ~ptw_walk_rdy_i;
    if (in_ptw_vld_i & (~ptw_v_q | ptw_walk_rdy_i)) begin
      ptw_v_d   = 1'b1;
      ptw_id_d  = in_ptw_id_i;
      ptw_pte_d = in_ptw_pte_i;
    end else if (ptw_v_q & ptw_walk_rdy_i) begin
      ptw_v_d   = 1'b0;
    end
    overflow_d = overflow_q | ld_drop | ptw_drop;
  end

  // PTW register and sticky overflow flag; only reset clears overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptw_v_q    <= 1'b0;
      ptw_id_q   <= '0;
      ptw_pte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptw_v_q    <= ptw_v_d;
      ptw_id_q   <= ptw_id_d;
      ptw_pte_q  <= ptw_pte_d;
      overflow_q <= overflow_d;
    end
  end

  assign l1d_ptw_walk_vld_o = ptw_v_q;
  assign l1d_ptw_walk_id_o  = ptw_id_q;
  assign l1d_ptw_walk_pte_o = ptw_pte_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_rvh_l1d_ld_wb_queue.sv
// tb_rvh_l1d_ld_wb_queue: directed, table-driven bench for the load-writeback
// queue with DEPTH=4 and STALL_THRESH=1, plus hand-written multi-cycle sequences.
module tb_rvh_l1d_ld_wb_queue;
  import rvh_l1d_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_wb_vld_i;
  logic [3:0]  in_rob_tag_i;
  logic [3:0]  in_prd_i;
  logic [63:0] in_data_i;
  logic        in_from_mlfb_i;
  logic [11:0] in_lsu_tag_i;
  logic        in_ptw_vld_i;
  logic [1:0]  in_ptw_id_i;
  logic [11:0] in_ptw_pte_i;
  logic        wb_rdy_i;
  logic        rob_vld, prf_vld;
  logic [3:0]  rob_tag, prf_tag;
  logic [63:0] prf_data;
  logic        prf_mlfb;
  logic [11:0] lsu_tag;
  logic        ptw_walk_rdy_i;
  logic        ptw_vld;
  logic [1:0]  ptw_id;
  logic [11:0] ptw_pte;
  logic        ld_stall;
  logic [2:0]  free_cnt;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  rvh_l1d_ld_wb_queue #(.DEPTH(4), .STALL_THRESH(1)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .in_wb_vld_i                    (in_wb_vld_i),
    .in_rob_tag_i                   (in_rob_tag_i),
    .in_prd_i                       (in_prd_i),
    .in_data_i                      (in_data_i),
    .in_from_mlfb_i                 (in_from_mlfb_i),
    .in_lsu_tag_i                   (in_lsu_tag_i),
    .in_ptw_vld_i                   (in_ptw_vld_i),
    .in_ptw_id_i                    (in_ptw_id_i),
    .in_ptw_pte_i                   (in_ptw_pte_i),
    .wb_rdy_i                       (wb_rdy_i),
    .l1d_rob_wb_vld_o               (rob_vld),
    .l1d_int_prf_wb_vld_o           (prf_vld),
    .l1d_rob_wb_rob_tag_o           (rob_tag),
    .l1d_int_prf_wb_tag_o           (prf_tag),
    .l1d_int_prf_wb_data_o          (prf_data),
    .l1d_int_prf_wb_vld_from_mlfb_o (prf_mlfb),
    .l1d_lsu_lsu_tag_o              (lsu_tag),
    .ptw_walk_rdy_i                 (ptw_walk_rdy_i),
    .l1d_ptw_walk_vld_o             (ptw_vld),
    .l1d_ptw_walk_id_o              (ptw_id),
    .l1d_ptw_walk_pte_o             (ptw_pte),
    .ld_stall_o                     (ld_stall),
    .free_cnt_o                     (free_cnt),
    .overflow_o                     (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic                 wbVld;
    rvh_l1d_ld_wb_entry_t wbIn;
    logic                 wbRdy;
    logic                 ptwVld;
    logic [1:0]           ptwId;
    logic [11:0]          ptwPte;
    logic                 ptwRdy;
    logic                 expVld;
    rvh_l1d_ld_wb_entry_t expHead;
    logic [2:0]           expFree;
    logic                 expStall;
    logic                 expPtwVld;
    logic [1:0]           expPtwId;
    logic [11:0]          expPtwPte;
    logic                 expOvf;
  } vec_t;

  vec_t vecs[10];

  function automatic rvh_l1d_ld_wb_entry_t mkEnt(input logic [3:0] t, input logic [3:0] p,
                                                 input logic [63:0] d, input logic m,
                                                 input logic [11:0] l);
    rvh_l1d_ld_wb_entry_t e;
    e.rob_tag = t; e.prd = p; e.data = d; e.from_mlfb = m; e.lsu_tag = l;
    return e;
  endfunction

  function automatic rvh_l1d_ld_wb_entry_t headNow();
    return mkEnt(rob_tag, prf_tag, prf_data, prf_mlfb, lsu_tag);
  endfunction

  // One comparison: count it, and report any difference.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic wbVld, input rvh_l1d_ld_wb_entry_t e, input logic wbRdy,
                               input logic pVld, input logic [1:0] pId, input logic [11:0] pPte,
                               input logic pRdy);
    in_wb_vld_i    = wbVld;
    in_rob_tag_i   = e.rob_tag;
    in_prd_i       = e.prd;
    in_data_i      = e.data;
    in_from_mlfb_i = e.from_mlfb;
    in_lsu_tag_i   = e.lsu_tag;
    wb_rdy_i       = wbRdy;
    in_ptw_vld_i   = pVld;
    in_ptw_id_i    = pId;
    in_ptw_pte_i   = pPte;
    ptw_walk_rdy_i = pRdy;
  endtask

  // Advance one edge, then drop the single-cycle pulses and settle.
  task automatic stepEdge();
    @(posedge clk);
    #1;
    in_wb_vld_i  = 1'b0;
    in_ptw_vld_i = 1'b0;
    #1;
  endtask

  rvh_l1d_ld_wb_entry_t eA, eB, eC, eD, eE, eF, eZ, eS;
  rvh_l1d_ld_wb_entry_t sb[$];

  initial begin
    eA = mkEnt(4'd1, 4'd1, 64'h11, 1'b0, 12'h001);
    eB = mkEnt(4'd2, 4'd2, 64'h22, 1'b1, 12'h002);
    eC = mkEnt(4'd3, 4'd3, 64'h33, 1'b0, 12'h003);
    eD = mkEnt(4'd4, 4'd4, 64'h44, 1'b0, 12'h004);
    eE = mkEnt(4'd5, 4'd6, 64'hE5, 1'b1, 12'h005);
    eF = mkEnt(4'd7, 4'd7, 64'hF7, 1'b0, 12'h007);
    eZ = mkEnt(4'd0, 4'd0, 64'h0, 1'b0, 12'h000);
    eS = mkEnt(4'd3, 4'd5, 64'hDEAD_BEEF, 1'b0, 12'h123);

    // Fill-to-full, full push with pop, full push without pop, drain; PTW held 3 cycles.
    //          wbVld in  rdy ptwV id    pte     pRdy eVld head free stall pV  pid   ppte    ovf
    vecs[0] = '{1'b1, eA, 1'b0, 1'b1, 2'd2, 12'hABC, 1'b0, 1'b1, eA, 3'd3, 1'b0, 1'b1, 2'd2, 12'hABC, 1'b0};
    vecs[1] = '{1'b1, eB, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eA, 3'd2, 1'b0, 1'b1, 2'd2, 12'hABC, 1'b0};
    vecs[2] = '{1'b1, eC, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eA, 3'd1, 1'b1, 1'b1, 2'd2, 12'hABC, 1'b0};
    vecs[3] = '{1'b1, eD, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eA, 3'd0, 1'b1, 1'b1, 2'd2, 12'hABC, 1'b0};
    vecs[4] = '{1'b1, eE, 1'b1, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, eB, 3'd0, 1'b1, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[5] = '{1'b1, eF, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eB, 3'd0, 1'b1, 1'b0, 2'd0, 12'h000, 1'b1};
    vecs[6] = '{1'b0, eZ, 1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eC, 3'd1, 1'b1, 1'b0, 2'd0, 12'h000, 1'b1};
    vecs[7] = '{1'b0, eZ, 1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eD, 3'd2, 1'b0, 1'b0, 2'd0, 12'h000, 1'b1};
    vecs[8] = '{1'b0, eZ, 1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, eE, 3'd3, 1'b0, 1'b0, 2'd0, 12'h000, 1'b1};
    vecs[9] = '{1'b0, eZ, 1'b1, 1'b0, 2'd0, 12'h000, 1'b0, 1'b0, eZ, 3'd4, 1'b0, 1'b0, 2'd0, 12'h000, 1'b1};

    rst = 1'b0;
    applyStimulus(1'b0, eZ, 1'b0, 1'b0, 2'd0, 12'h0, 1'b0);
    #22;
    rst = 1'b1;
    @(posedge clk);
    #2;

    // Reset state.
    checkOutput("reset_vld", {127'd0, rob_vld}, 128'd0);
    checkOutput("reset_prf_vld", {127'd0, prf_vld}, 128'd0);
    checkOutput("reset_free", {125'd0, free_cnt}, 128'd4);
    checkOutput("reset_stall", {127'd0, ld_stall}, 128'd0);
    checkOutput("reset_ptw_vld", {127'd0, ptw_vld}, 128'd0);
    checkOutput("reset_ovf", {127'd0, overflow}, 128'd0);

    // Single push with ready high.
    applyStimulus(1'b1, eS, 1'b1, 1'b0, 2'd0, 12'h0, 1'b0);
    #1;
`ifdef RVH_L1D_LD_WB_BYPASS_EN
    checkOutput("single_bypass_vld", {127'd0, rob_vld}, 128'd1);
    checkOutput("single_bypass_head", {43'd0, headNow()}, {43'd0, eS});
`else
    checkOutput("single_same_cycle_vld", {127'd0, rob_vld}, 128'd0);
`endif
    stepEdge();
`ifdef RVH_L1D_LD_WB_BYPASS_EN
    checkOutput("single_after_vld", {127'd0, rob_vld}, 128'd0);
    checkOutput("single_after_free", {125'd0, free_cnt}, 128'd4);
`else
    checkOutput("single_next_vld", {127'd0, rob_vld}, 128'd1);
    checkOutput("single_next_head", {43'd0, headNow()}, {43'd0, eS});
    checkOutput("single_next_free", {125'd0, free_cnt}, 128'd3);
`endif
    stepEdge();
    checkOutput("single_drained_vld", {127'd0, rob_vld}, 128'd0);
    checkOutput("single_drained_free", {125'd0, free_cnt}, 128'd4);

    // Table-driven fill, overflow and drain sequence.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wbVld, vecs[i].wbIn, vecs[i].wbRdy, vecs[i].ptwVld,
                    vecs[i].ptwId, vecs[i].ptwPte, vecs[i].ptwRdy);
      stepEdge();
      checkOutput($sformatf("vec%0d_vld", i), {127'd0, rob_vld}, {127'd0, vecs[i].expVld});
      if (vecs[i].expVld)
        checkOutput($sformatf("vec%0d_head", i), {43'd0, headNow()}, {43'd0, vecs[i].expHead});
      checkOutput($sformatf("vec%0d_free", i), {125'd0, free_cnt}, {125'd0, vecs[i].expFree});
      checkOutput($sformatf("vec%0d_stall", i), {127'd0, ld_stall}, {127'd0, vecs[i].expStall});
      checkOutput($sformatf("vec%0d_ptw_vld", i), {127'd0, ptw_vld}, {127'd0, vecs[i].expPtwVld});
      if (vecs[i].expPtwVld)
        checkOutput($sformatf("vec%0d_ptw_pl", i), {114'd0, ptw_id, ptw_pte},
                    {114'd0, vecs[i].expPtwId, vecs[i].expPtwPte});
      checkOutput($sformatf("vec%0d_ovf", i), {127'd0, overflow}, {127'd0, vecs[i].expOvf});
    end

    // Ten pushes with random ready: pop order must match push order across wrap.
    begin
      int pushed = 0;
      int popped = 0;
      int iter = 0;
      while (popped < 10 && iter < 300) begin
        logic doPush;
        logic rdy;
        rvh_l1d_ld_wb_entry_t e;
        doPush = (pushed < 10) && (sb.size() < 4) && ($urandom_range(0, 3) != 0);
        rdy    = 1'($urandom_range(0, 1));
        e      = mkEnt(4'(pushed), ~4'(pushed), 64'hC0DE_0000 + 64'(pushed),
                       1'(pushed & 1), 12'h100 + 12'(pushed));
        applyStimulus(doPush, e, rdy, 1'b0, 2'd0, 12'h0, 1'b0);
        if (doPush) begin
          sb.push_back(e);
          pushed++;
        end
        #1;
        if (rob_vld && rdy) begin
          if (sb.size() == 0) begin
            checkOutput("order_unexpected_vld", {127'd0, rob_vld}, 128'd0);
          end else begin
            checkOutput($sformatf("order_pop%0d", popped), {43'd0, headNow()}, {43'd0, sb[0]});
            void'(sb.pop_front());
            popped++;
          end
        end
        @(posedge clk);
        #1;
        in_wb_vld_i = 1'b0;
        #1;
        iter++;
      end
      checkOutput("order_all_popped", 128'(popped), 128'd10);
    end

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mkEnt(4'(i), 4'(i), 64'(i), 1'b0, 12'(i)), 1'b0, 1'b0, 2'd0, 12'h0, 1'b0);
      stepEdge();
    end
    checkOutput("prereset_free", {125'd0, free_cnt}, 128'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_vld", {127'd0, rob_vld}, 128'd0);
    checkOutput("async_reset_free", {125'd0, free_cnt}, 128'd4);
    checkOutput("async_reset_ovf", {127'd0, overflow}, 128'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // PTW: held response, then a second pulse while blocked is dropped.
    applyStimulus(1'b0, eZ, 1'b0, 1'b1, 2'd2, 12'hABC, 1'b0);
    stepEdge();
    checkOutput("ptw_held_vld", {127'd0, ptw_vld}, 128'd1);
    checkOutput("ptw_held_ovf", {127'd0, overflow}, 128'd0);
    applyStimulus(1'b0, eZ, 1'b0, 1'b1, 2'd1, 12'h555, 1'b0);
    stepEdge();
    checkOutput("ptw_drop_ovf", {127'd0, overflow}, 128'd1);
    checkOutput("ptw_drop_payload", {114'd0, ptw_id, ptw_pte}, {114'd0, 2'd2, 12'hABC});
    stepEdge();
    checkOutput("ptw_ovf_sticky", {127'd0, overflow}, 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
